// File: rtl/sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver
//
// Time-multiplexed driver for an N-digit 7-segment display. Packed BCD digits
// and per-digit decimal points are captured into a shadow register only at
// frame boundaries, so a display frame never mixes old and new values. One
// digit is lit per SCAN_DIV clocks. Codes 10-15 show hex glyphs when HEX_EN
// is set. Leading zeros can be blanked.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          1: scanning active; 0: display dark and scan position frozen
//   blank_lz    1: blank leading zeros (digit 0 is never blanked)
//   bcd_in      packed digits, digit i at bcd_in[4i+3:4i], digit 0 = LSD
//   dp_in       decimal point per digit
//   seg         {a,b,c,d,e,f,g} for the active digit, seg[6] = a
//   dp          decimal point of the active digit
//   an          one-hot digit enable
//   frame_done  one-cycle pulse after the last digit slot of a frame
//
// All pin outputs come straight from registers. Only a constant XOR is applied
// to set the board polarity, so the pins are glitch-free. The polarity
// inversion also applies during reset.
// ---------------------------------------------------------------------------
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int HEX_EN      = 0,
    parameter int SEG_ACT_LOW = 0,
    parameter int AN_ACT_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    blank_lz,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Per-digit lookup arrays are padded to a power of two. This keeps every
    // value of idx_reg a legal index, even when NUM_DIGITS is not a power of two.
    localparam int NSLOT = 1 << IDX_W;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_MASK = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_MASK  = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_MASK  = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};

    // ST_WAIT_LOAD: nothing has been captured yet since reset. The first
    // enabled cycle loads the shadow without waiting for a frame boundary.
    typedef enum logic [0:0] {
        ST_WAIT_LOAD = 1'b0,
        ST_SCAN      = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_reg, shadow_bcd_next;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg, shadow_dp_next;
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic                    frame_done_reg, frame_done_next;

    logic                    slot_end;
    logic                    frame_end;
    logic                    load_shadow;

    logic [3:0]              digit_arr [NSLOT];
    logic [NSLOT-1:0]        dp_arr;
    // upper_zero[i] is 1 when digit i and every more-significant digit are zero.
    logic [NSLOT:0]          upper_zero;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [3:0]              cur_code;
    logic                    cur_blank;
    logic [6:0]              cur_glyph;

    // ------------------------------------------------------------------
    // Shadow unpacking and leading-zero chain
    // ------------------------------------------------------------------
    assign upper_zero[NSLOT] = 1'b1;

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NUM_DIGITS) begin : g_real
                assign digit_arr[gi]  = shadow_bcd_reg[4*gi +: 4];
                assign dp_arr[gi]     = shadow_dp_reg[gi];
                assign upper_zero[gi] = (shadow_bcd_reg[4*gi +: 4] == 4'd0) && upper_zero[gi+1];
            end else begin : g_pad
                assign digit_arr[gi]  = 4'd0;
                assign dp_arr[gi]     = 1'b0;
                assign upper_zero[gi] = 1'b1;
            end
        end

        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
            assign an_onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign cur_code  = digit_arr[idx_reg];
    assign cur_blank = blank_lz && (idx_reg != '0) && upper_zero[idx_reg];

    // ------------------------------------------------------------------
    // Glyph decode (logical, active-high, {a,b,c,d,e,f,g})
    // ------------------------------------------------------------------
    always_comb begin
        cur_glyph = 7'h00;
        case (cur_code)
            4'd0:  cur_glyph = 7'h7E;
            4'd1:  cur_glyph = 7'h30;
            4'd2:  cur_glyph = 7'h6D;
            4'd3:  cur_glyph = 7'h79;
            4'd4:  cur_glyph = 7'h33;
            4'd5:  cur_glyph = 7'h5B;
            4'd6:  cur_glyph = 7'h5F;
            4'd7:  cur_glyph = 7'h70;
            4'd8:  cur_glyph = 7'h7F;
            4'd9:  cur_glyph = 7'h7B;
            4'd10: cur_glyph = (HEX_EN != 0) ? 7'h77 : 7'h00;
            4'd11: cur_glyph = (HEX_EN != 0) ? 7'h1F : 7'h00;
            4'd12: cur_glyph = (HEX_EN != 0) ? 7'h4E : 7'h00;
            4'd13: cur_glyph = (HEX_EN != 0) ? 7'h3D : 7'h00;
            4'd14: cur_glyph = (HEX_EN != 0) ? 7'h4F : 7'h00;
            4'd15: cur_glyph = (HEX_EN != 0) ? 7'h47 : 7'h00;
            default: cur_glyph = 7'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan position: prescaler and digit index, both frozen while en=0
    // ------------------------------------------------------------------
    assign slot_end  = en && (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    always_comb begin
        cnt_next = cnt_reg;
        idx_next = idx_reg;
        if (en) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next = '0;
                idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow-load control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        load_shadow = 1'b0;
        case (state_reg)
            ST_WAIT_LOAD: begin
                if (en) begin
                    load_shadow = 1'b1;
                    state_next  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                load_shadow = frame_end;
            end
            default: begin
                state_next = ST_WAIT_LOAD;
            end
        endcase
    end

    always_comb begin
        shadow_bcd_next = shadow_bcd_reg;
        shadow_dp_next  = shadow_dp_reg;
        if (load_shadow) begin
            shadow_bcd_next = bcd_in;
            shadow_dp_next  = dp_in;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: shows the digit selected by the index before this edge
    // ------------------------------------------------------------------
    always_comb begin
        an_next         = '0;
        seg_next        = 7'h00;
        dp_next         = 1'b0;
        frame_done_next = 1'b0;
        if (en) begin
            an_next         = an_onehot;
            seg_next        = cur_blank ? 7'h00 : cur_glyph;
            dp_next         = dp_arr[idx_reg];
            frame_done_next = frame_end;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_WAIT_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shadow_bcd_reg <= '0;
            shadow_dp_reg  <= '0;
            seg_reg        <= 7'h00;
            dp_reg         <= 1'b0;
            an_reg         <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            shadow_bcd_reg <= shadow_bcd_next;
            shadow_dp_reg  <= shadow_dp_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign seg        = seg_reg ^ SEG_MASK;
    assign dp         = dp_reg ^ DP_MASK;
    assign an         = an_reg ^ AN_MASK;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//
// Two instances share one set of inputs:
//   u_pos : HEX_EN=0, active-high seg/an
//   u_neg : HEX_EN=1, active-low seg/dp and an
// A behavioural model tracks the enabled-cycle position inside a 16-cycle
// frame. It is checked against both instances on every falling edge. Table
// vectors and hand-written sequences cover glyphs, blanking, tear-free
// update, enable gating and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          blank_lz;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;

    logic [6:0]    seg_a, seg_b;
    logic          dp_a, dp_b;
    logic [3:0]    an_a, an_b;
    logic          fd_a, fd_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;

    sevenseg_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(DIV), .HEX_EN(0), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)
    ) u_pos (
        .clk(clk), .rst_n(rst_n), .en(en), .blank_lz(blank_lz),
        .bcd_in(bcd_in), .dp_in(dp_in),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a)
    );

    sevenseg_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(DIV), .HEX_EN(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) u_neg (
        .clk(clk), .rst_n(rst_n), .en(en), .blank_lz(blank_lz),
        .bcd_in(bcd_in), .dp_in(dp_in),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input int code, input bit hex);
        if (code >= 10 && !hex) return 7'h00;
        return GLYPH[code];
    endfunction

    // ------------------------------------------------------------------
    // Reference model. m_pos is the count of enabled cycles inside the
    // current frame. The active digit is m_pos / DIV.
    // ------------------------------------------------------------------
    int         m_pos;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    bit          m_loaded;
    int          m_code;
    bit          m_blank;
    logic [3:0]  m_an;
    logic        m_dpo;
    logic        m_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos    <= 0;
            m_bcd    <= '0;
            m_dp     <= '0;
            m_loaded <= 1'b0;
            m_code   <= 0;
            m_blank  <= 1'b1;
            m_an     <= '0;
            m_dpo    <= 1'b0;
            m_fd     <= 1'b0;
        end else if (en) begin
            m_an    <= 4'b0001 << (m_pos / DIV);
            m_code  <= int'((m_bcd >> (4 * (m_pos / DIV))) & 16'hF);
            m_blank <= blank_lz && ((m_pos / DIV) > 0) && ((m_bcd >> (4 * (m_pos / DIV))) == 16'h0);
            m_dpo   <= m_dp[m_pos / DIV];
            m_fd    <= (m_pos == FRAME - 1);
            if (m_pos == FRAME - 1 || !m_loaded) begin
                m_bcd    <= bcd_in;
                m_dp     <= dp_in;
                m_loaded <= 1'b1;
            end
            m_pos <= (m_pos + 1) % FRAME;
        end else begin
            m_an    <= '0;
            m_blank <= 1'b1;
            m_dpo   <= 1'b0;
            m_fd    <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            logic [6:0] es_a, es_b;
            logic [3:0] ea_b;
            logic       ed_b;
            es_a = m_blank ? 7'h00 : ref_glyph(m_code, 1'b0);
            es_b = m_blank ? 7'h00 : ref_glyph(m_code, 1'b1);
            es_b = ~es_b;
            ea_b = ~m_an;
            ed_b = ~m_dpo;
            check("model_seg_a", seg_a, es_a);
            check("model_an_a",  an_a,  m_an);
            check("model_dp_a",  dp_a,  m_dpo);
            check("model_fd_a",  fd_a,  m_fd);
            check("model_seg_b", seg_b, es_b);
            check("model_an_b",  an_b,  ea_b);
            check("model_dp_b",  dp_b,  ed_b);
            check("model_fd_b",  fd_b,  m_fd);
        end
    end

    // Advances at least one falling edge, then waits for a frame_done pulse.
    task automatic wait_fd();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (fd_a !== 1'b1 && k < 4 * FRAME);
        if (fd_a !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_frame_done actual=timeout required=pulse within %0d clks", 4 * FRAME);
        end
    endtask

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dpv;
        logic        lz;
        logic [27:0] exp_a;  // logical seg per digit, digit 0 in [6:0]
        logic [27:0] exp_b;  // logical seg per digit with hex glyphs
    } vec_t;

    vec_t vecs [9];

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        blank_lz = 1'b0;
        bcd_in   = '0;
        dp_in    = '0;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h30, 7'h6D, 7'h79, 7'h33}, {7'h30, 7'h6D, 7'h79, 7'h33}};
        vecs[1] = '{16'h0050, 4'b0101, 1'b1, {7'h00, 7'h00, 7'h5B, 7'h7E}, {7'h00, 7'h00, 7'h5B, 7'h7E}};
        vecs[2] = '{16'h0000, 4'b1000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}, {7'h00, 7'h00, 7'h00, 7'h7E}};
        vecs[3] = '{16'h3210, 4'b0010, 1'b0, {7'h79, 7'h6D, 7'h30, 7'h7E}, {7'h79, 7'h6D, 7'h30, 7'h7E}};
        vecs[4] = '{16'h7654, 4'b1111, 1'b0, {7'h70, 7'h5F, 7'h5B, 7'h33}, {7'h70, 7'h5F, 7'h5B, 7'h33}};
        vecs[5] = '{16'hBA98, 4'b0001, 1'b0, {7'h00, 7'h00, 7'h7B, 7'h7F}, {7'h1F, 7'h77, 7'h7B, 7'h7F}};
        vecs[6] = '{16'hFEDC, 4'b0100, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00}, {7'h47, 7'h4F, 7'h3D, 7'h4E}};
        vecs[7] = '{16'h0050, 4'b0000, 1'b0, {7'h7E, 7'h7E, 7'h5B, 7'h7E}, {7'h7E, 7'h7E, 7'h5B, 7'h7E}};
        vecs[8] = '{16'h00A0, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}, {7'h00, 7'h00, 7'h77, 7'h7E}};

        // ---- reset state ------------------------------------------------
        repeat (3) @(negedge clk);
        check("rst_seg_a", seg_a, 7'h00);
        check("rst_an_a",  an_a,  4'b0000);
        check("rst_dp_a",  dp_a,  1'b0);
        check("rst_fd_a",  fd_a,  1'b0);
        check("rst_seg_b", seg_b, 7'h7F);
        check("rst_an_b",  an_b,  4'b1111);
        check("rst_dp_b",  dp_b,  1'b1);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        en = 1'b1;

        // ---- table vectors: one loaded frame per record ---------------
        for (int v = 0; v < 9; v++) begin
            bcd_in   = vecs[v].bcd;
            dp_in    = vecs[v].dpv;
            blank_lz = vecs[v].lz;
            wait_fd();
            for (int i = 0; i < N; i++) begin
                logic [6:0] sb;
                logic [3:0] ab;
                @(negedge clk);
                sb = vecs[v].exp_b[7*i +: 7];
                sb = ~sb;
                ab = 4'b0001 << i;
                ab = ~ab;
                check("tbl_seg_a", seg_a, vecs[v].exp_a[7*i +: 7]);
                check("tbl_seg_b", seg_b, sb);
                check("tbl_an_a",  an_a,  4'b0001 << i);
                check("tbl_an_b",  an_b,  ab);
                check("tbl_dp_a",  dp_a,  vecs[v].dpv[i]);
                repeat (DIV - 1) @(negedge clk);
            end
            $display("vector %0d bcd=%h dp=%b lz=%0d checked", v, vecs[v].bcd, vecs[v].dpv, vecs[v].lz);
        end

        // ---- frame_done rate: exactly two pulses in 32 clocks ----------
        begin
            int pulses;
            pulses = 0;
            wait_fd();
            for (int c = 0; c < 2 * FRAME; c++) begin
                @(negedge clk);
                if (fd_a === 1'b1) pulses++;
            end
            check("fd_rate", pulses, 2);
            $display("frame_done rate: %0d pulses in %0d clks", pulses, 2 * FRAME);
        end

        // ---- tear-free update ------------------------------------------
        bcd_in   = 16'h1234;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        wait_fd();
        @(negedge clk);
        check("tear_d0_old", seg_a, 7'h33);
        bcd_in = 16'h5678;
        repeat (DIV) @(negedge clk);
        check("tear_d1_old", seg_a, 7'h79);
        repeat (DIV) @(negedge clk);
        check("tear_d2_old", seg_a, 7'h6D);
        repeat (DIV) @(negedge clk);
        check("tear_d3_old", seg_a, 7'h30);
        wait_fd();
        @(negedge clk);
        check("tear_d0_new", seg_a, 7'h7F);
        repeat (DIV) @(negedge clk);
        check("tear_d1_new", seg_a, 7'h70);
        $display("tear-free update 1234->5678 checked");

        // ---- enable gating: dark and frozen, then resume at slot 0 -----
        wait_fd();
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("dis_an_a",  an_a,  4'b0000);
            check("dis_seg_a", seg_a, 7'h00);
            check("dis_an_b",  an_b,  4'b1111);
            check("dis_fd_a",  fd_a,  1'b0);
        end
        en = 1'b1;
        @(negedge clk);
        check("resume_an_a", an_a, 4'b0001);
        check("resume_an_b", an_b, 4'b1110);
        repeat (DIV) @(negedge clk);
        check("resume_next_an_a", an_a, 4'b0010);
        $display("enable gating checked");

        // ---- polarity: digit '8' drives all active-low segments low ----
        bcd_in = 16'h0008;
        wait_fd();
        @(negedge clk);
        check("pol_8_seg_b", seg_b, 7'h00);
        check("pol_8_seg_a", seg_a, 7'h7F);
        $display("active-low digit 8 checked");

        // ---- randomized run against the model --------------------------
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                logic [15:0] b;
                b = '0;
                for (int d = 0; d < N; d++) begin
                    if ($urandom_range(0, 1) == 1) b[4*d +: 4] = 4'($urandom_range(1, 15));
                end
                bcd_in = b;
                dp_in  = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end
        $display("random run of 600 cycles done");

        // ---- asynchronous reset in the middle of a slot ----------------
        en = 1'b1;
        bcd_in = 16'h8888;
        repeat (2 * FRAME) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_seg_a", seg_a, 7'h00);
        check("arst_an_a",  an_a,  4'b0000);
        check("arst_dp_a",  dp_a,  1'b0);
        check("arst_fd_a",  fd_a,  1'b0);
        check("arst_seg_b", seg_b, 7'h7F);
        check("arst_an_b",  an_b,  4'b1111);
        $display("async reset mid-slot checked");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
